// File: rtl/vo_kp_pkg.sv
// vo_kp_pkg: keypoint entry layout and collector state encoding
package vo_kp_pkg;
  localparam int X_W       = 10;
  localparam int Y_W       = 10;
  localparam int SCORE_W   = 8;
  localparam int TRIG_W    = 12;
  localparam int KP_W      = X_W + Y_W + SCORE_W + 2 * TRIG_W;
  localparam int SIN_LSB   = 0;
  localparam int COS_LSB   = SIN_LSB + TRIG_W;
  localparam int SCORE_LSB = COS_LSB + TRIG_W;
  localparam int Y_LSB     = SCORE_LSB + SCORE_W;
  localparam int X_LSB     = Y_LSB + Y_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_TAIL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  function automatic logic [KP_W-1:0] kp_pack(
    input logic [X_W-1:0]     x,
    input logic [Y_W-1:0]     y,
    input logic [SCORE_W-1:0] score,
    input logic [TRIG_W-1:0]  cos_v,
    input logic [TRIG_W-1:0]  sin_v
  );
    return {x, y, score, cos_v, sin_v};
  endfunction
endpackage

// File: rtl/kp_sync_fifo.sv
// kp_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers and flush
module kp_sync_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW-1:0]    o_count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;

  assign o_count = wptr - rptr;
  assign o_empty = wptr == rptr;
  assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign o_dout  = mem[rptr[AW-1:0]];

  // pointer advance; flush returns both to zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(i_push);
      rptr <= rptr + PW'(i_pop);
    end
  end

  // storage write; a push into a full FIFO only happens alongside a pop
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) mem[wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/keypoint_collector.sv
// keypoint_collector: per-frame keypoint capture, cap/drop accounting and streaming
module keypoint_collector
  import vo_kp_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int MAX_KP = 500,
  parameter int CNT_W  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_end,
  input  logic               i_flag,
  input  logic [X_W-1:0]     i_coord_x,
  input  logic [Y_W-1:0]     i_coord_y,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [TRIG_W-1:0]  i_cos,
  input  logic [TRIG_W-1:0]  i_sin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [TRIG_W-1:0]  o_cos,
  output logic [TRIG_W-1:0]  o_sin,
  output logic               o_frame_done,
  output logic [CNT_W-1:0]   o_kp_count,
  output logic [CNT_W-1:0]   o_drop_count
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_KP);

  state_t           state, state_n;
  logic [CNT_W-1:0] acc, drp, acc_n, drp_n;
  logic             pend, pend_n, clr, restart, req, pop, accept, drop, done, go;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_cnt;
  logic [KP_W-1:0]  head;

  kp_sync_fifo #(.WIDTH(KP_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (restart),
    .i_push  (accept),
    .i_din   (kp_pack(i_coord_x, i_coord_y, i_score, i_cos, i_sin)),
    .i_pop   (pop),
    .o_dout  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_cnt)
  );

  assign o_valid = !fifo_empty;
  assign pop     = o_valid && i_ready;
  assign o_x     = o_valid ? head[X_LSB +: X_W] : '0;
  assign o_y     = o_valid ? head[Y_LSB +: Y_W] : '0;
  assign o_score = o_valid ? head[SCORE_LSB +: SCORE_W] : '0;
  assign o_cos   = o_valid ? head[COS_LSB +: TRIG_W] : '0;
  assign o_sin   = o_valid ? head[SIN_LSB +: TRIG_W] : '0;

  // accept rule, saturating counters and frame sequencing
  always_comb begin
    restart = state == S_FRAME && i_start;
    req     = (state == S_FRAME || state == S_TAIL) && i_flag && !restart;
    accept  = req && acc < MAX_C && (!fifo_full || pop);
    drop    = (req && !accept) || (state == S_DRAIN && i_flag);
    done    = state == S_DRAIN && fifo_cnt == '0;
    go      = pend || i_start;
    acc_n   = acc + CNT_W'(accept && acc != '1);
    drp_n   = drp + CNT_W'(drop && drp != '1);
    state_n = state;
    pend_n  = pend;
    clr     = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = i_start ? S_FRAME : S_IDLE;
        clr     = i_start;
      end
      S_FRAME: begin
        state_n = (i_end && !restart) ? S_TAIL : S_FRAME;
        clr     = restart;
      end
      S_TAIL: begin
        state_n = S_DRAIN;
        pend_n  = go;
      end
      default: begin
        state_n = done ? (go ? S_FRAME : S_IDLE) : S_DRAIN;
        pend_n  = go && !done;
        clr     = done && go;
      end
    endcase
  end

  // state, counters and the held end-of-frame summary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      pend         <= 1'b0;
      acc          <= '0;
      drp          <= '0;
      o_frame_done <= 1'b0;
      o_kp_count   <= '0;
      o_drop_count <= '0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      acc          <= clr ? '0 : acc_n;
      drp          <= clr ? '0 : drp_n;
      o_frame_done <= done;
      if (done) begin
        o_kp_count   <= acc_n;
        o_drop_count <= drp_n;
      end
    end
  end
endmodule
